// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - sprite word field layout, default sprite size and scanner FSM encoding
package collision_pkg;

  localparam int SPR_EN_BIT = 29;
  localparam int X_MSB      = 28;
  localparam int X_LSB      = 19;
  localparam int Y_MSB      = 18;
  localparam int Y_LSB      = 9;
  localparam int COORD_W    = 10;

  localparam int DEF_SPR_W  = 20;
  localparam int DEF_SPR_H  = 20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH_REF = 3'd1;
  localparam logic [2:0] ST_SCAN      = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - axis-aligned box overlap test for two equal-size sprites
module aabb_overlap
  import collision_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic               overlap
);

  // One extra bit so x+SPR_W near the screen edge cannot wrap.
  localparam logic [COORD_W:0] W_EXT = (COORD_W + 1)'(SPR_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W + 1)'(SPR_H);

  logic [COORD_W:0] x1_e, y1_e, x2_e, y2_e;

  assign x1_e = {1'b0, x1};
  assign y1_e = {1'b0, y1};
  assign x2_e = {1'b0, x2};
  assign y2_e = {1'b0, y2};

  assign overlap = (x1_e + W_EXT > x2_e) && (x2_e + W_EXT > x1_e) &&
                   (y1_e + H_EXT > y2_e) && (y2_e + H_EXT > y1_e);

endmodule

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - scans the sprite bank for boxes overlapping a reference sprite
module collision_scanner
  import collision_pkg::*;
#(
  parameter int N_SPRITES = 32,
  parameter int ADDR_W    = 5,
  parameter int SPR_W     = DEF_SPR_W,
  parameter int SPR_H     = DEF_SPR_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] ref_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              hit,
  output logic [ADDR_W-1:0] hit_addr,
  output logic [ADDR_W:0]   hit_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SPRITES - 1);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  ref_idx;
  logic [ADDR_W-1:0]  scan_idx;
  logic [ADDR_W-1:0]  cmp_idx;
  logic               cmp_valid;
  logic               scan_first;
  logic [COORD_W-1:0] ref_x, ref_y;
  logic               overlap;
  logic               is_hit;
  logic               unused_rd_bits;

  assign unused_rd_bits = ^{rd_data[31:30], rd_data[Y_LSB-1:0]};

  // On the SCAN entry cycle the reference word is on rd_data; a disabled
  // reference must suppress the very first scan read.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state)
      ST_FETCH_REF: begin
        rd_en   = 1'b1;
        rd_addr = ref_idx;
      end
      ST_SCAN: begin
        rd_en   = scan_first ? rd_data[SPR_EN_BIT] : 1'b1;
        rd_addr = scan_idx;
      end
      default: ;
    endcase
  end

  assign busy = (state == ST_FETCH_REF) || (state == ST_SCAN) || (state == ST_DRAIN);
  assign done = (state == ST_FINISH);

  aabb_overlap #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H)
  ) u_overlap (
    .x1     (ref_x),
    .y1     (ref_y),
    .x2     (rd_data[X_MSB:X_LSB]),
    .y2     (rd_data[Y_MSB:Y_LSB]),
    .overlap(overlap)
  );

  assign is_hit = cmp_valid && (cmp_idx != ref_idx) && rd_data[SPR_EN_BIT] && overlap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ref_idx    <= '0;
      scan_idx   <= '0;
      cmp_idx    <= '0;
      cmp_valid  <= 1'b0;
      scan_first <= 1'b0;
      ref_x      <= '0;
      ref_y      <= '0;
      hit        <= 1'b0;
      hit_addr   <= '0;
      hit_count  <= '0;
    end else begin
      cmp_valid <= rd_en && (state == ST_SCAN);
      cmp_idx   <= rd_addr;

      if (is_hit) begin
        hit_count <= hit_count + 1'b1;
        if (!hit) begin
          hit      <= 1'b1;
          hit_addr <= cmp_idx;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH_REF;
            ref_idx   <= ref_addr;
            hit       <= 1'b0;
            hit_addr  <= '0;
            hit_count <= '0;
          end
        end
        ST_FETCH_REF: begin
          state      <= ST_SCAN;
          scan_idx   <= '0;
          scan_first <= 1'b1;
        end
        ST_SCAN: begin
          scan_first <= 1'b0;
          if (scan_first) begin
            ref_x <= rd_data[X_MSB:X_LSB];
            ref_y <= rd_data[Y_MSB:Y_LSB];
          end
          if (scan_first && !rd_data[SPR_EN_BIT]) begin
            state <= ST_FINISH;
          end else if (scan_idx == LAST_IDX) begin
            state <= ST_DRAIN;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        ST_DRAIN:  state <= ST_FINISH;
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - table-driven scoreboard bench for collision_scanner
module tb_collision_scanner;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] ref_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          busy, done, hit;
  logic [AW-1:0] hit_addr;
  logic [AW:0]   hit_count;

  collision_scanner #(.N_SPRITES(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .ref_addr(ref_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .hit(hit), .hit_addr(hit_addr), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [N];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic [5:0] idx;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } spr_t;

  typedef struct packed {
    logic [4:0]       ref_idx;
    logic [9:0]       rx;
    logic [9:0]       ry;
    logic             ren;
    spr_t [2:0]       s;
    logic             e_hit;
    logic [4:0]       e_addr;
    logic [5:0]       e_cnt;
    logic [31:0]      e_lat;
    logic [31:0]      e_rden;
  } vec_t;

  typedef struct packed {
    logic        hit;
    logic [4:0]  addr;
    logic [5:0]  cnt;
    logic [31:0] lat;
    logic [31:0] rden;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic en, input logic [9:0] x, input logic [9:0] y);
    return {2'b10, en, x, y, 9'h1a5};
  endfunction

  function automatic spr_t sp(input int idx, input int x, input int y, input logic en);
    spr_t r;
    r.idx = 6'(idx); r.x = 10'(x); r.y = 10'(y); r.en = en;
    return r;
  endfunction

  function automatic vec_t mkvec(input int ri, input int rx, input int ry, input logic ren,
                                 input spr_t a, input spr_t b, input spr_t c,
                                 input logic eh, input int ea, input int ec, input int el, input int erd);
    vec_t v;
    v.ref_idx = 5'(ri); v.rx = 10'(rx); v.ry = 10'(ry); v.ren = ren;
    v.s[0] = a; v.s[1] = b; v.s[2] = c;
    v.e_hit = eh; v.e_addr = 5'(ea); v.e_cnt = 6'(ec); v.e_lat = ea >= 0 ? el : el; v.e_rden = erd;
    return v;
  endfunction

  // Filler sprites sit on the reference but are disabled, so they must never count.
  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) mem[i] = mk(1'b0, v.rx, v.ry);
    mem[v.ref_idx] = mk(v.ren, v.rx, v.ry);
    for (int k = 0; k < 3; k++)
      if (v.s[k].idx < 6'd32) mem[v.s[k].idx[4:0]] = mk(v.s[k].en, v.s[k].x, v.s[k].y);
  endtask

  task automatic run_scan(input string nm, input vec_t v, input bit poke);
    exp_t e;
    int   cycles;
    int   rden;
    logic h_keep;
    logic [AW:0] c_keep;
    e.hit = v.e_hit; e.addr = v.e_addr; e.cnt = v.e_cnt; e.lat = v.e_lat; e.rden = v.e_rden;
    load(v);
    @(posedge clk); #1;
    ref_addr = v.ref_idx;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    ref_addr = 5'd0;
    cycles = 1;
    rden   = rd_en ? 1 : 0;
    while (!done && cycles < 200) begin
      start = (poke && (cycles == 5 || cycles == 20)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (rd_en) rden++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check({nm, " latency"}, cycles, e.lat);
    check({nm, " rd_en cycles"}, rden, e.rden);
    check({nm, " hit"}, 32'(hit), 32'(e.hit));
    check({nm, " hit_addr"}, 32'(hit_addr), 32'(e.addr));
    check({nm, " hit_count"}, 32'(hit_count), 32'(e.cnt));
    check({nm, " busy at done"}, 32'(busy), 0);
    h_keep = hit;
    c_keep = hit_count;
    @(posedge clk); #1;
    check({nm, " done one cycle"}, 32'(done), 0);
    check({nm, " result hold"}, {h_keep, c_keep}, {e.hit, e.cnt});
  endtask

  vec_t vt[7];
  spr_t none;

  initial begin
    int c1, c2;
    none  = sp(63, 0, 0, 1'b0);
    vt[0] = mkvec(3, 100, 100, 1, sp(7, 110, 115, 1), none, none, 1, 7, 1, 35, 33);
    vt[1] = mkvec(0, 100, 100, 1, sp(5, 120, 100, 1), sp(6, 100, 120, 1), none, 0, 0, 0, 35, 33);
    vt[2] = mkvec(0, 100, 100, 1, sp(2, 105, 105, 1), sp(9, 90, 90, 1), sp(30, 119, 81, 1), 1, 2, 3, 35, 33);
    vt[3] = mkvec(4, 100, 100, 0, sp(1, 100, 100, 1), none, none, 0, 0, 0, 3, 1);
    vt[4] = mkvec(1, 1015, 1015, 1, sp(2, 1020, 1000, 1), none, none, 1, 2, 1, 35, 33);
    vt[5] = mkvec(1, 1015, 0, 1, sp(0, 0, 0, 1), none, none, 0, 0, 0, 35, 33);
    vt[6] = mkvec(10, 500, 500, 1, sp(11, 500, 500, 0), sp(12, 519, 519, 1), sp(31, 481, 481, 1), 1, 12, 2, 35, 33);

    reset = 1'b1; start = 1'b0; ref_addr = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {rd_en, rd_addr, busy, done, hit, hit_addr, hit_count},
          {1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0});
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_scan($sformatf("vec%0d", i), vt[i], (i == 0 || i == 6));

    // Abort mid-scan at T10, then rerun the same scan cleanly.
    load(vt[0]);
    @(posedge clk); #1;
    ref_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("busy before abort", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort outputs", {rd_en, rd_addr, busy, done, hit, hit_addr, hit_count},
          {1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0});
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle after abort", {rd_en, busy, done, hit, hit_count}, 10'd0);
    run_scan("rerun", vt[0], 1'b1);

    // start held high: ignored in the done cycle, accepted on the next one.
    load(vt[0]);
    @(posedge clk); #1;
    ref_addr = 5'd3; start = 1'b1;
    c1 = 0;
    while (!done && c1 < 200) begin @(posedge clk); #1; c1++; end
    check("held start first done", c1, 35);
    c2 = 0;
    do begin @(posedge clk); #1; c2++; end while (!done && c2 < 200);
    start = 1'b0;
    check("held start gap", c2, 36);
    check("held start hit_addr", {hit, hit_addr, hit_count}, {1'b1, 5'd7, 6'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
